// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared FSM encoding and widths for the multi-cycle divider.
package div_unit_pkg;
    localparam int DATA_WIDTH = 32;
    typedef logic [DATA_WIDTH-1:0] data_bus_t;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract iteration on the {remainder, quotient} pair.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    // The shifted upper half needs one extra bit before the trial subtract.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvs};
    assign rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit DIV/DIVU for EX; holds the pipeline via stall_request while busy.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH  = DATA_WIDTH,
    parameter int CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall_all,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stall_request,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CNT_W = $clog2(CYCLES + 1);

    div_state_t state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, rem_s, quo_s;
    logic neg_q, neg_r, accept, last;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem(rem_q),
        .quo(quo_q),
        .dvs(dvs_q),
        .rem_next(rem_s),
        .quo_next(quo_s)
    );

    assign stall_request = !rst && !flush && ((state == IDLE && start) || state == CALC);
    assign done = state == DONE;

    always_comb begin
        accept = state == IDLE && start && !flush && !stall_all;
        last = count == CNT_W'(CYCLES - 1);
        state_n = state;
        count_n = count;
        if (flush) begin
            state_n = IDLE;
            count_n = '0;
        end else if (!stall_all) begin
            case (state)
                IDLE: begin
                    state_n = start ? (divisor == '0 ? DONE : CALC) : IDLE;
                    count_n = '0;
                end
                CALC: begin
                    state_n = last ? DONE : CALC;
                    count_n = count + CNT_W'(1);
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            if (accept) begin
                rem_q <= '0;
                quo_q <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                dvs_q <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
                neg_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                neg_r <= is_signed && dividend[WIDTH-1];
                if (divisor == '0) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end
            end else if (state == CALC && !flush && !stall_all) begin
                rem_q <= rem_s;
                quo_q <= quo_s;
                // Sign fix-up lands together with the final step, so DONE presents the final result.
                if (last) begin
                    quotient  <= neg_q ? -quo_s : quo_s;
                    remainder <= neg_r ? -rem_s : rem_s;
                end
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors; a driver queues expected results, a monitor checks on done.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic stall_all = 1'b0;
    logic start = 1'b0;
    logic is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic stall_request, done;
    logic [31:0] quotient, remainder;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    div_unit dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .stall_all(stall_all),
        .start(start),
        .is_signed(is_signed),
        .dividend(dividend),
        .divisor(divisor),
        .stall_request(stall_request),
        .done(done),
        .quotient(quotient),
        .remainder(remainder)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Issues one division at the next cycle; stall_all is held over [sl, sh] relative to T0.
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic [31:0] r, input int lat,
                           input int sl, input int sh);
        @(negedge clk);
        sb.push_back('{q, r, cyc + lat});
        start = 1'b1;
        is_signed = sg;
        dividend = a;
        divisor = b;
        for (int t = 0; t <= lat; t++) begin
            stall_all = (t >= sl && t <= sh);
            #1;
            check("stall_request", {31'd0, stall_request}, {31'd0, t < lat});
            if (t == lat) break;
            @(negedge clk);
        end
        start = 1'b0;
        stall_all = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        start = 1'b1;
        #12;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_stall_request", {31'd0, stall_request}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, -1, -1);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, -1, -1);
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33, -1, -1);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33, -1, -1);
        run_div(1'b0, 32'h00001234, 32'd0, 32'hFFFFFFFF, 32'h00001234, 1, -1, -1);
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 33, -1, -1);
        run_div(1'b0, 32'd5, 32'd10, 32'd0, 32'd5, 33, -1, -1);
        run_div(1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 33, -1, -1);

        // Flush at T10 abandons the division; a new one starts at T12.
        @(negedge clk);
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 32'd100;
        divisor = 32'd7;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_stall_request", {31'd0, stall_request}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1;
        check("flush_idle", {31'd0, stall_request}, 32'd0);
        check("flush_no_done", {31'd0, done}, 32'd0);
        run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, -1, -1);

        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 38, 5, 9);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1;
        dividend = 32'd100;
        divisor = 32'd7;
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_stall_request", {31'd0, stall_request}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        check("async_rst_quotient", quotient, 32'd0);
        check("async_rst_remainder", remainder, 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider in the EX stage, serving DIV/DIVU.
- It is the requesting end of the pipeline stall protocol: it raises stall_request, which drives the controller's EX stall-request input, for as long as a division is in progress.
- It obeys the controller's global freeze (stall_all) and exception flush.
- Results go to the HI/LO write path: quotient to LO, remainder to HI.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is supported; the parameter exists for bench scaling.
- CYCLES, WIDTH, number of iteration cycles in CALC. Must equal WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  exception flush from the pipeline controller.
- stall_all  in  1  global freeze (bus/memory wait).
- start  in  1  a DIV/DIVU instruction is present in EX. Held high while EX is stalled.
- is_signed  in  1  1 = DIV, 0 = DIVU. Sampled only at accept.
- dividend  in  WIDTH  rs operand. Sampled only at accept.
- divisor  in  WIDTH  rt operand. Sampled only at accept.
- stall_request  out  1  to the controller's EX request input.
- done  out  1  result valid this cycle.
- quotient  out  WIDTH  written to LO.
- remainder  out  WIDTH  written to HI.

Behaviour:
- Reset (async, immediate): state=IDLE, count=0, done=0, quotient=0, remainder=0. stall_request=0 while rst is high.
- Priority each cycle: rst > flush > stall_all > normal operation.
- States:
  - IDLE: wait for start.
  - CALC: one restoring shift-subtract step per cycle.
  - DONE: result held, done=1.
- stall_request (combinational) = !flush && ((state==IDLE && start) || state==CALC).
  - It is 0 in DONE, which lets EX advance in the same cycle that done is high.
- Accept: in IDLE with start=1, flush=0, stall_all=0.
  - Latch sign flags and the absolute values of the operands (absolute value only when is_signed).
  - Clear the 2*WIDTH partial remainder.
  - Go to CALC with count=0.
- Divisor zero at accept: skip CALC and go directly to DONE with quotient=all-ones and remainder=dividend (raw). No exception is raised.
- CALC, per cycle:
  - Shift the partial remainder/quotient left by 1.
  - Trial-subtract |divisor| from the upper half. If the result is non-negative, keep it and set quotient bit 0.
  - count increments. At count==CYCLES-1 the next state is DONE.
- DONE entry, sign fix-up (registered):
  - quotient is negated if is_signed and the operand signs differ.
  - remainder takes the sign of the dividend.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000 and remainder=0 via natural wrap. No flag.
- Latency: accept cycle T0; CALC occupies T1..T32; done=1 at T33. stall_request is high T0..T32.
- DONE: done=1 and outputs held. Next cycle returns to IDLE unless stall_all is high; DONE holds while stall_all is high.
  - If start is high in the cycle after DONE (a back-to-back division), it is a new accept in IDLE.
- stall_all: freezes state, count, datapath and outputs exactly. stall_request keeps its value. No accept occurs during stall_all.
- flush, any state:
  - Next state IDLE; count cleared; done=0 next cycle.
  - quotient and remainder keep their old values (don't-care).
  - stall_request drops in the same cycle.
- flush and start in the same cycle: no accept.
- Mid-operation reset: immediate return to reset values; no partial result is visible.

Decomposition:
- WIDTH-derived buses (DATA_BUS) and the state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) go in the shared bus.v header alongside the existing ADDR_BUS definitions.
- One sub-module is natural: div_step, the combinational single iteration (partial remainder, divisor → next partial remainder, quotient bit). The bench reuses it as a reference.
- The FSM, counter and sign fix-up stay in div_unit.

Test Plan:
- DIVU 100/7, start held until done:
  - stall_request=1 T0..T32; done=1 at T33 with quotient=14, remainder=2; stall_request=0 at T33.
- DIV -7/2 (0xFFFFFFF9 / 2):
  - quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - Repeat with 7/-2: quotient=0xFFFFFFFD, remainder=1.
- DIV 0x80000000 / 0xFFFFFFFF:
  - quotient=0x80000000, remainder=0, done at T33.
- DIVU 0x1234 / 0:
  - done at T1 with quotient=0xFFFFFFFF, remainder=0x1234.
  - stall_request high only at T0.
- DIVU 100/7 with flush pulsed at T10:
  - stall_request=0 at T10; state IDLE at T11; done never asserts.
  - A new start at T12 of 9/3 yields quotient=3, remainder=0 at T45.
- DIVU 100/7 with stall_all high T5..T9 (5 cycles):
  - count frozen; done at T38 with quotient=14, remainder=2.
  - Also assert rst asynchronously mid-CALC: outputs clear immediately and stall_request=0.
